fifo_block_packer: RTL and testbench

- Read-side consumer of the asynchronous symbol FIFO in the encoder datapath.
- Pops DATA_W-bit symbols from the FIFO read port and packs SYM_CNT of them into one K_BITS-wide information block.
- Presents each block to the LDPC encoder core over a valid/ready handshake.
- Runs entirely in the FIFO read clock domain.

---
 rtl/fifo_block_packer_if.sv | 38 +++
 rtl/fifo_block_packer.sv | 77 +++++++
 tb/tb_fifo_block_packer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_block_packer_if.sv
// Handshake bundle between the symbol FIFO read port, the block packer and the LDPC encoder.
// The master modport is the packer's view; the slave modport is the FIFO/encoder side.
interface fifo_block_packer_if #(
    parameter int unsigned DATA_W = 3,
    parameter int unsigned K_BITS = 24,
    parameter int unsigned CNT_W  = 16
);
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_data;
    logic [K_BITS-1:0] blk_data;
    logic              blk_valid;
    logic              blk_ready;
    logic [CNT_W-1:0]  blk_cnt;
    logic              busy;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  blk_ready,
        output fifo_rd_en,
        output blk_data,
        output blk_valid,
        output blk_cnt,
        output busy
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output blk_ready,
        input  fifo_rd_en,
        input  blk_data,
        input  blk_valid,
        input  blk_cnt,
        input  busy
    );
endinterface

// File: rtl/fifo_block_packer.sv
// Pops DATA_W-bit symbols from the FIFO read port, packs SYM_CNT of them LSB-first into one
// K_BITS block and offers it to the encoder over valid/ready. No prefetch while a block waits.
module fifo_block_packer #(
    parameter int unsigned DATA_W = 3,
    parameter int unsigned K_BITS = 24,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    fifo_block_packer_if.master bus
);
    localparam int unsigned SYM_CNT = K_BITS / DATA_W;
    localparam int unsigned CW      = $clog2(SYM_CNT + 1);
    localparam logic [CW-1:0] MaxReq  = CW'(SYM_CNT);
    localparam logic [CW-1:0] LastSym = CW'(SYM_CNT - 1);

    typedef enum logic [0:0] {StFill, StOut} state_e;

    state_e            state_q;
    logic [CW-1:0]     req_cnt_q;
    logic [CW-1:0]     rcv_cnt_q;
    logic              rd_en_d1_q;
    logic [K_BITS-1:0] blk_data_q;
    logic              blk_valid_q;
    logic [CNT_W-1:0]  blk_cnt_q;
    logic              rd_en;

    // Empty flag is honoured combinationally so an empty FIFO is never popped.
    assign rd_en = !rst && (state_q == StFill) && !bus.fifo_empty && (req_cnt_q < MaxReq);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFill;
            req_cnt_q   <= '0;
            rcv_cnt_q   <= '0;
            rd_en_d1_q  <= 1'b0;
            blk_data_q  <= '0;
            blk_valid_q <= 1'b0;
            blk_cnt_q   <= '0;
        end else begin
            rd_en_d1_q <= rd_en;
            unique case (state_q)
                StFill: begin
                    if (rd_en) begin
                        req_cnt_q <= req_cnt_q + CW'(1);
                    end
                    // Read data lags the pop by one cycle; slot index follows captures, not pops.
                    if (rd_en_d1_q) begin
                        blk_data_q[int'(rcv_cnt_q) * DATA_W +: DATA_W] <= bus.fifo_data;
                        if (rcv_cnt_q == LastSym) begin
                            state_q     <= StOut;
                            blk_valid_q <= 1'b1;
                            req_cnt_q   <= '0;
                            rcv_cnt_q   <= '0;
                        end else begin
                            rcv_cnt_q <= rcv_cnt_q + CW'(1);
                        end
                    end
                end
                StOut: begin
                    if (bus.blk_ready) begin
                        blk_valid_q <= 1'b0;
                        blk_cnt_q   <= blk_cnt_q + CNT_W'(1);
                        state_q     <= StFill;
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.blk_data   = blk_data_q;
    assign bus.blk_valid  = blk_valid_q;
    assign bus.blk_cnt    = blk_cnt_q;
    assign bus.busy       = (state_q == StOut) || (req_cnt_q != '0) || (rcv_cnt_q != '0);
endmodule

// File: tb/tb_fifo_block_packer.sv
// Bench for fifo_block_packer: directed vector table, hand-written corner sequences and a random
// phase, all checked every cycle against a queue-based model of popped symbols and blocks.
module tb_fifo_block_packer;
    logic clk;
    logic rst;

    fifo_block_packer_if #(.DATA_W(3), .K_BITS(24), .CNT_W(16)) bus ();
    fifo_block_packer_if #(.DATA_W(3), .K_BITS(24), .CNT_W(3))  bus2 ();

    fifo_block_packer #(.DATA_W(3), .K_BITS(24), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Narrow-counter twin sees identical stimulus so wrap-around is reached quickly.
    fifo_block_packer #(.DATA_W(3), .K_BITS(24), .CNT_W(3)) dut_w3 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.master)
    );
    assign bus2.fifo_empty = bus.fifo_empty;
    assign bus2.fifo_data  = bus.fifo_data;
    assign bus2.blk_ready  = bus.blk_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          pops = 0;
    int unsigned exp_cnt = 0;
    logic [2:0]  sym_q[$];
    logic [2:0]  popped_q[$];
    logic [2:0]  pending;
    logic        pend_valid = 1'b0;
    int          cd = 0;
    logic        mvalid = 1'b0;
    logic        prev_hold = 1'b0;
    logic [23:0] prev_data;
    logic        rst_v, ready_v, gap_v, gap_tog_v;
    logic        s_rd, s_valid, s_busy;
    logic [23:0] s_data;
    logic [15:0] s_cnt;
    logic [2:0]  s_cnt2;

    typedef struct {
        logic        gap_tog;
        int          hold;
        logic [23:0] exp_data;
        int          exp_pops;
        int          exp_lat;
        int          exp_cnt;
    } vec_t;
    vec_t vecs[3];

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic logic [23:0] pack8();
        logic [23:0] r = '0;
        for (int i = 0; i < 8; i++) r[i*3 +: 3] = popped_q[i];
        return r;
    endfunction

    task automatic preload(input logic [2:0] a0, a1, a2, a3, a4, a5, a6, a7);
        sym_q.push_back(a0); sym_q.push_back(a1); sym_q.push_back(a2); sym_q.push_back(a3);
        sym_q.push_back(a4); sym_q.push_back(a5); sym_q.push_back(a6); sym_q.push_back(a7);
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) sym_q.push_back(3'($urandom));
    endtask

    // One clock: drive inputs at negedge, sample and check against the model, update the model.
    task automatic cycle();
        logic acc, exp_rd, gap;
        @(negedge clk);
        cyc++;
        rst = rst_v;
        gap = gap_tog_v ? (((cyc / 2) % 2) == 1) : gap_v;
        bus.fifo_data  = pend_valid ? pending : 3'($urandom);
        bus.fifo_empty = (sym_q.size() == 0) || gap;
        bus.blk_ready  = ready_v;
        #1;
        s_rd = bus.fifo_rd_en; s_valid = bus.blk_valid; s_busy = bus.busy;
        s_data = bus.blk_data; s_cnt = bus.blk_cnt; s_cnt2 = bus2.blk_cnt;
        if (cd > 0) begin
            cd--;
            if (cd == 0) mvalid = 1'b1;
        end
        exp_rd = !rst && !bus.fifo_empty && !mvalid && (popped_q.size() < 8);
        chk("blk_valid", 32'(s_valid), 32'(mvalid));
        chk("fifo_rd_en", 32'(s_rd), 32'(exp_rd));
        chk("busy", 32'(s_busy), 32'(mvalid || (popped_q.size() != 0)));
        chk("blk_cnt", 32'(s_cnt), exp_cnt % 65536);
        chk("blk_cnt_w3", 32'(s_cnt2), exp_cnt % 8);
        chk("w3_valid_match", 32'(bus2.blk_valid), 32'(s_valid));
        if (prev_hold) chk("hold_data", 32'(s_data), 32'(prev_data));
        acc = s_valid && bus.blk_ready && !rst;
        if (acc) begin
            if (popped_q.size() < 8) begin
                chk("accept_sym_count", popped_q.size(), 8);
            end else begin
                chk("blk_data", 32'(s_data), 32'(pack8()));
                for (int i = 0; i < 8; i++) void'(popped_q.pop_front());
            end
            exp_cnt++;
            mvalid = 1'b0;
        end
        prev_hold = s_valid && !acc && !rst;
        prev_data = s_data;
        if (s_rd) begin
            pending = (sym_q.size() > 0) ? sym_q.pop_front() : 3'd0;
            pend_valid = 1'b1;
            popped_q.push_back(pending);
            pops++;
            if (popped_q.size() == 8) cd = 2;
        end else begin
            pend_valid = 1'b0;
        end
        if (rst) begin
            popped_q.delete(); sym_q.delete();
            cd = 0; mvalid = 1'b0; exp_cnt = 0; pend_valid = 1'b0; prev_hold = 1'b0;
        end
    endtask

    initial begin
        int p0, f, vc;
        int vq[$];
        vecs[0] = '{gap_tog: 1'b0, hold: 0,  exp_data: 24'o07654321, exp_pops: 8, exp_lat: 9,
                    exp_cnt: 1};
        vecs[1] = '{gap_tog: 1'b1, hold: 0,  exp_data: 24'o07654321, exp_pops: 8, exp_lat: -1,
                    exp_cnt: 2};
        vecs[2] = '{gap_tog: 1'b0, hold: 10, exp_data: 24'o07654321, exp_pops: 8, exp_lat: 9,
                    exp_cnt: 3};
        rst = 1'b1; rst_v = 1'b0; ready_v = 1'b0; gap_v = 1'b0; gap_tog_v = 1'b0;
        bus.fifo_empty = 1'b1; bus.fifo_data = '0; bus.blk_ready = 1'b0;
        repeat (3) @(posedge clk);
        cycle();
        chk("rst_blk_data", 32'(s_data), 0);
        chk("rst_blk_valid", 32'(s_valid), 0);
        chk("rst_blk_cnt", 32'(s_cnt), 0);
        chk("rst_busy", 32'(s_busy), 0);

        foreach (vecs[k]) begin
            gap_tog_v = vecs[k].gap_tog;
            ready_v = (vecs[k].hold == 0);
            preload(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0);
            p0 = pops; f = -1; vc = -1;
            for (int i = 0; i < 80 && vc < 0; i++) begin
                cycle();
                if (s_rd && f < 0) f = cyc;
                if (s_valid) vc = cyc;
            end
            chk("vec_valid_seen", 32'(vc >= 0), 1);
            chk("vec_pops", pops - p0, vecs[k].exp_pops);
            chk("vec_data", 32'(s_data), 32'(vecs[k].exp_data));
            if (vecs[k].exp_lat >= 0) chk("vec_latency", vc - f, vecs[k].exp_lat);
            gap_tog_v = 1'b0;
            if (vecs[k].hold > 0) begin
                push_rand(8);  // FIFO non-empty while stalled: no prefetch allowed
                repeat (vecs[k].hold - 1) cycle();
                chk("hold_valid", 32'(s_valid), 1);
                chk("hold_cnt", 32'(s_cnt), vecs[k].exp_cnt - 1);
                ready_v = 1'b1;
                cycle();
            end
            cycle();
            chk("vec_cnt", 32'(s_cnt), vecs[k].exp_cnt);
        end

        // Back-to-back with FIFO never empty: 10-cycle block period.
        push_rand(24);
        ready_v = 1'b1;
        for (int i = 0; i < 80 && vq.size() < 3; i++) begin
            cycle();
            if (s_valid) vq.push_back(cyc);
        end
        chk("b2b_pulses", vq.size(), 3);
        if (vq.size() == 3) begin
            chk("b2b_space1", vq[1] - vq[0], 10);
            chk("b2b_space2", vq[2] - vq[1], 10);
        end
        cycle();
        chk("b2b_cnt", 32'(s_cnt), 6);

        // Reset after 5 pops of a block, then a fresh block must land at slot 0.
        p0 = pops;
        for (int i = 0; i < 40 && (pops - p0) < 5; i++) cycle();
        chk("pre_rst_pops", pops - p0, 5);
        rst_v = 1'b1;
        cycle();
        rst_v = 1'b0;
        cycle();
        chk("post_rst_valid", 32'(s_valid), 0);
        chk("post_rst_data", 32'(s_data), 0);
        chk("post_rst_busy", 32'(s_busy), 0);
        chk("post_rst_cnt", 32'(s_cnt), 0);
        preload(3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0);
        vc = -1;
        for (int i = 0; i < 40 && vc < 0; i++) begin
            cycle();
            if (s_valid) vc = cyc;
        end
        chk("fresh_valid_seen", 32'(vc >= 0), 1);
        chk("fresh_data", 32'(s_data), 32'(24'o01234567));

        // Seven more blocks: the 3-bit counter must wrap to 0 while the wide one reads 8.
        push_rand(56);
        vq.delete();
        for (int i = 0; i < 120 && vq.size() < 7; i++) begin
            cycle();
            if (s_valid) vq.push_back(cyc);
        end
        cycle();
        chk("wrap_w3", 32'(s_cnt2), 0);
        chk("cnt_8", 32'(s_cnt), 8);

        // Random gaps, backpressure and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            gap_v = ($urandom_range(0, 3) == 0);
            ready_v = ($urandom_range(0, 2) != 0);
            rst_v = ($urandom_range(0, 599) == 0);
            if (sym_q.size() < 4) push_rand(4);
            cycle();
        end
        rst_v = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
